// File: rtl/tty_tx_fifo_if.sv
// Memory-bus port of the buffered stdout peripheral: request/response signals
// shared between the core (master) and the peripheral (slave).
`timescale 1ns/1ps
interface tty_tx_fifo_if;
  logic [31:0] addr;
  logic [2:0]  size;
  logic        valid;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output addr, size, valid, write, wdata, input rdata, ready);
  modport slave  (input addr, size, valid, write, wdata, output rdata, ready);
endinterface

// File: rtl/tty_tx_fifo.sv
// Buffered stdout peripheral: bus-written bytes queue in a FIFO and drain as
// 8N1 frames on tx. Define TTY_TX_FIFO_CRLF_EN to expand each LF into CR+LF.
`timescale 1ns/1ps
module tty_tx_fifo #(
  parameter logic [31:0] BASE         = 32'h3000,
  parameter int          DEPTH        = 16,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  tty_tx_fifo_if.slave  bus,
  output logic          tx,
  output logic          busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef TTY_TX_FIFO_CRLF_EN
    , CR
`endif
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wptr, rptr, level;
  logic            full, empty;
  logic            hit_data, hit_stat, accept, push, pop;
  logic [7:0]      head;
  logic [31:0]     status;
  logic            unused_bits;

  assign level    = wptr - rptr;
  assign full     = (level == PW'(DEPTH));
  assign empty    = (level == '0);
  assign head     = mem[rptr[AW-1:0]];
  assign busy     = (state != IDLE) || !empty;
  assign hit_data = (bus.addr == BASE);
  assign hit_stat = (bus.addr == BASE + 32'd4);
  assign pop      = (state == IDLE) && !empty;

  // A write to a full FIFO may still go in when the same edge pops the head.
  assign accept = bus.valid && (hit_data || hit_stat) && !bus.ready &&
                  !(hit_data && bus.write && full && !pop);
  assign push   = accept && hit_data && bus.write;
  assign status = {16'b0, 8'(level), 5'b0, busy, full, empty};

  assign unused_bits = ^{bus.size, bus.wdata[31:8]};

  // NOTE: the storage array has no reset; pointers alone define what is valid,
  // so clearing the entries would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= bus.wdata[7:0];
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      bus.ready <= accept;
      bus.rdata <= (accept && hit_stat && !bus.write) ? status : '0;
    end
  end

`ifdef TTY_TX_FIFO_CRLF_EN
  logic lf_pending;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef TTY_TX_FIFO_CRLF_EN
      lf_pending <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg    <= head;
`ifdef TTY_TX_FIFO_CRLF_EN
            if (head == 8'h0A) begin
              shreg      <= 8'h0D;
              lf_pending <= 1'b1;
            end
`endif
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
`ifdef TTY_TX_FIFO_CRLF_EN
            if (lf_pending) state <= CR;
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef TTY_TX_FIFO_CRLF_EN
        // One-cycle gap between the CR frame and the LF frame it precedes.
        CR: begin
          shreg      <= 8'h0A;
          lf_pending <= 1'b0;
          tx         <= 1'b0;
          baud_cnt   <= '0;
          state      <= START;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
